// File: rtl/selection_pkg.sv
// Shared types, default geometry and tile numbering for the selection-square controller.
package selection_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } sel_state_t;

  localparam int unsigned GRID_N  = 4;
  localparam int unsigned S_WIDTH = 100;

  // Row-major tile number; grid_n lets a re-parameterised top reuse it.
  function automatic logic [3:0] tile_index(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned grid_n = GRID_N);
    return 4'(row * grid_n + col);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button to single-cycle press event: 2-FF sync, debounce, rising-edge pulse.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1, sync2;
  logic             stable, stable_prev;
  logic [CNT_W-1:0] cnt;

  // Stable level follows the synchronized level only after an unbroken run of differences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      cnt         <= '0;
      pulse       <= 1'b0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      stable_prev <= stable;
      pulse       <= stable & ~stable_prev;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/selection_ctrl.sv
// Selection-square position, frame-synchronous offset commit and CPU start handshake.
module selection_ctrl
  import selection_pkg::*;
#(
  parameter int unsigned GRID_N          = selection_pkg::GRID_N,
  parameter int unsigned S_WIDTH         = selection_pkg::S_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       frame_start,
  output logic [8:0] h_offset,
  output logic [8:0] v_offset,
  output logic [3:0] sel_index,
  output logic       start_req,
  input  logic       start_ack,
  input  logic       proc_done,
  output logic       busy
);

  localparam int unsigned POS_W = (GRID_N > 1) ? $clog2(GRID_N) : 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(GRID_N - 1);

  // Event bit order: 0 up, 1 down, 2 left, 3 right, 4 sel.
  logic [4:0] raw_btn;
  logic [4:0] ev;

  assign raw_btn = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_btn[i]),
      .pulse(ev[i])
    );
  end

  sel_state_t       state_q, state_d;
  logic [POS_W-1:0] col_q, col_d, row_q, row_d;
  logic [3:0]       sel_d;

  // Next state, pending position and select latch; moves only count while idle.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    sel_d   = sel_index;
    unique case (state_q)
      IDLE: begin
        if (ev[4]) begin
          sel_d   = tile_index(32'(row_q), 32'(col_q), GRID_N);
          state_d = REQ;
        end else begin
          if (ev[3] && !ev[2] && col_q != POS_MAX) col_d = col_q + 1'b1;
          if (ev[2] && !ev[3] && col_q != '0)      col_d = col_q - 1'b1;
          if (ev[1] && !ev[0] && row_q != POS_MAX) row_d = row_q + 1'b1;
          if (ev[0] && !ev[1] && row_q != '0)      row_d = row_q - 1'b1;
        end
      end
      REQ:     if (start_ack) state_d = BUSY;
      BUSY:    if (proc_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Offsets take the pending position only at frame start so the square never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      sel_index <= '0;
      h_offset  <= '0;
      v_offset  <= '0;
      start_req <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      sel_index <= sel_d;
      start_req <= (state_d == REQ);
      busy      <= (state_d != IDLE);
      if (frame_start) begin
        h_offset <= 9'(32'(col_q) * S_WIDTH);
        v_offset <= 9'(32'(row_q) * S_WIDTH);
      end
    end
  end

endmodule

// File: tb/tb_selection_ctrl.sv
// Directed bench for selection_ctrl with a short debounce window.
module tb_selection_ctrl;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btns = '0;
  logic       frame_start = 1'b0;
  logic       start_ack = 1'b0;
  logic       proc_done = 1'b0;
  logic [8:0] h_offset, v_offset;
  logic [3:0] sel_index;
  logic       start_req, busy;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  selection_ctrl #(
    .GRID_N(4),
    .S_WIDTH(100),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btns[0]),
    .btn_down   (btns[1]),
    .btn_left   (btns[2]),
    .btn_right  (btns[3]),
    .btn_sel    (btns[4]),
    .frame_start(frame_start),
    .h_offset   (h_offset),
    .v_offset   (v_offset),
    .sel_index  (sel_index),
    .start_req  (start_req),
    .start_ack  (start_ack),
    .proc_done  (proc_done),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the masked buttons long enough for one event, then release and let it settle.
  task automatic press(input logic [4:0] mask);
    btns = mask;
    tick(DEB + 6);
    btns = '0;
    tick(DEB + 6);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  initial begin
    int n_ev;
    int ev_at;
    n_ev  = 0;
    ev_at = 0;

    // Reset
    tick(1);
    #3 rst_n = 1'b1;
    tick(1);
    check("rst_h_offset", 32'(h_offset), 0);
    check("rst_v_offset", 32'(v_offset), 0);
    check("rst_sel_index", 32'(sel_index), 0);
    check("rst_start_req", 32'(start_req), 0);
    check("rst_busy", 32'(busy), 0);

    // Debounce: 3-cycle glitch, then a clean 10-cycle press
    btns[3] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      if (dut.ev[3]) n_ev++;
    end
    btns[3] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      if (dut.ev[3]) n_ev++;
    end
    btns[3] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (dut.ev[3]) begin
        n_ev++;
        ev_at = i;
      end
    end
    check("deb_h_before_frame", 32'(h_offset), 0);
    btns[3] = 1'b0;
    for (int i = 1; i <= int'(DEB) + 6; i++) begin
      tick(1);
      if (dut.ev[3]) n_ev++;
    end
    check("deb_event_count", 32'(n_ev), 1);
    check("deb_event_cycle", 32'(ev_at), 7);
    check("deb_h_still_before_frame", 32'(h_offset), 0);
    frame();
    check("deb_h_after_frame", 32'(h_offset), 100);
    check("deb_v_after_frame", 32'(v_offset), 0);

    // Saturation at the far edges
    repeat (5) press(5'b01000);
    repeat (5) press(5'b00010);
    frame();
    check("sat_h", 32'(h_offset), 300);
    check("sat_v", 32'(v_offset), 300);
    press(5'b01100);
    frame();
    check("lr_cancel_h", 32'(h_offset), 300);

    // Move to col=2,row=1 with a combined horizontal+vertical press, then one more up
    press(5'b00101);
    press(5'b00001);
    frame();
    check("pos_h", 32'(h_offset), 200);
    check("pos_v", 32'(v_offset), 100);

    // Handshake
    btns = 5'b10000;
    tick(7);
    check("hs_req_before", 32'(start_req), 0);
    tick(1);
    check("hs_req_set", 32'(start_req), 1);
    check("hs_sel_index", 32'(sel_index), 6);
    check("hs_busy_set", 32'(busy), 1);
    n_ev = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (start_req) n_ev++;
    end
    check("hs_req_held", 32'(n_ev), 10);
    btns = '0;
    tick(DEB + 6);
    start_ack = 1'b1;
    tick(1);
    start_ack = 1'b0;
    check("hs_req_clear", 32'(start_req), 0);
    check("hs_busy_held", 32'(busy), 1);

    // Lockout while busy
    press(5'b11010);
    frame();
    check("lock_h", 32'(h_offset), 200);
    check("lock_v", 32'(v_offset), 100);
    check("lock_sel", 32'(sel_index), 6);
    check("lock_no_req", 32'(start_req), 0);
    check("lock_busy", 32'(busy), 1);
    proc_done = 1'b1;
    tick(1);
    proc_done = 1'b0;
    check("done_busy_clear", 32'(busy), 0);

    // Select together with a move: move dropped, pre-move tile latched
    press(5'b11000);
    check("selmove_sel", 32'(sel_index), 6);
    check("selmove_req", 32'(start_req), 1);
    start_ack = 1'b1;
    tick(1);
    start_ack = 1'b0;
    frame();
    check("selmove_h", 32'(h_offset), 200);
    check("selmove_busy", 32'(busy), 1);

    // Asynchronous reset while busy
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_req", 32'(start_req), 0);
    check("arst_h", 32'(h_offset), 0);
    check("arst_v", 32'(v_offset), 0);
    check("arst_sel", 32'(sel_index), 0);
    tick(1);
    #2 rst_n = 1'b1;
    tick(1);
    press(5'b01000);
    frame();
    check("post_rst_h", 32'(h_offset), 100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
